// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder emulating a 12-bit ADC: 4 zero bits then the sample, MSB first. Pin-to-pulse latency is SYNC_STAGES+1 clk.
// sample_ready is high only in IDLE, with no backpressure on the SPI side. Define SPI_RESP_RAMP_EN to transmit an internal ramp instead of sample_in.
module spi_adc_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [15:0] rx_data,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_meta, cs_meta, mosi_meta;
  logic                   sck_prev, cs_prev, mosi_sync;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [FRAME_BITS-1:0]  shreg, shreg_next;
  logic [15:0]            rxreg, rxreg_next;
  logic [CW-1:0]          bitcnt, bitcnt_next;
  logic [15:0]            rx_data_next;
  logic                   done_next, err_next, miso_next, oe_next;
  logic [11:0]            tx_sample;

`ifdef SPI_RESP_RAMP_EN
  logic [11:0] ramp, ramp_next;
  assign tx_sample = ramp;
`else
  logic [11:0] hold, hold_next;
  assign tx_sample = hold;
`endif

  // Edge pulses are registered, so mosi is delayed one extra stage to stay aligned with sck_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta  <= '0;
      cs_meta   <= '1;
      mosi_meta <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
      mosi_sync <= 1'b0;
      sck_rise  <= 1'b0;
      sck_fall  <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sck_meta  <= {sck_meta[SYNC_STAGES-2:0], sck};
      cs_meta   <= {cs_meta[SYNC_STAGES-2:0], cs_n};
      mosi_meta <= {mosi_meta[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_meta[SYNC_STAGES-1];
      cs_prev   <= cs_meta[SYNC_STAGES-1];
      mosi_sync <= mosi_meta[SYNC_STAGES-1];
      sck_rise  <= sck_meta[SYNC_STAGES-1] & ~sck_prev;
      sck_fall  <= ~sck_meta[SYNC_STAGES-1] & sck_prev;
      cs_fall   <= ~cs_meta[SYNC_STAGES-1] & cs_prev;
      cs_rise   <= cs_meta[SYNC_STAGES-1] & ~cs_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      rxreg      <= '0;
      bitcnt     <= '0;
      rx_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
`ifdef SPI_RESP_RAMP_EN
      ramp       <= '0;
`else
      hold       <= '0;
`endif
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      rxreg      <= rxreg_next;
      bitcnt     <= bitcnt_next;
      rx_data    <= rx_data_next;
      frame_done <= done_next;
      frame_err  <= err_next;
      miso       <= miso_next;
      miso_oe    <= oe_next;
`ifdef SPI_RESP_RAMP_EN
      ramp       <= ramp_next;
`else
      hold       <= hold_next;
`endif
    end
  end

  assign sample_ready = (state == IDLE);

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    rxreg_next   = rxreg;
    bitcnt_next  = bitcnt;
    rx_data_next = rx_data;
    done_next    = 1'b0;
    err_next     = 1'b0;
`ifdef SPI_RESP_RAMP_EN
    ramp_next    = ramp;
`else
    hold_next    = hold;
    // Accepting in the cs_fall cycle lets that sample go out in the frame it opens.
    if (sample_valid && sample_ready) hold_next = sample_in;
`endif

    case (state)
      IDLE: begin
        if (cs_fall) state_next = LOAD;
      end
      LOAD: begin
        shreg_next  = FRAME_BITS'(tx_sample);
        bitcnt_next = '0;
        state_next  = SHIFT;
      end
      SHIFT: begin
        if (sck_rise) begin
          rxreg_next = {rxreg[14:0], mosi_sync};
          if (bitcnt != CW'(FRAME_BITS)) bitcnt_next = bitcnt + CW'(1);
        end
        // Shifting on the falling edge keeps miso stable across the master's rising-edge sample.
        if (sck_fall) shreg_next = {shreg[FRAME_BITS-2:0], 1'b0};
        if (cs_rise) begin
          if (bitcnt == CW'(FRAME_BITS)) begin
            state_next = DONE;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
      end
      DONE: begin
        rx_data_next = rxreg;
        done_next    = 1'b1;
        state_next   = IDLE;
`ifdef SPI_RESP_RAMP_EN
        ramp_next    = ramp + 12'd1;
`endif
      end
      default: state_next = IDLE;
    endcase

    miso_next = (state_next == SHIFT) ? shreg_next[FRAME_BITS-1] : 1'b0;
    oe_next   = (state_next == LOAD) || (state_next == SHIFT);
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a bit-level SPI master drives frames, a scoreboard queue holds the expected outcome of each frame.
module tb_spi_adc_responder;

  localparam int FB   = 16;
  localparam int HALF = 6;
`ifdef SPI_RESP_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        miso, miso_oe, sample_ready, frame_done, frame_err;
  logic [15:0] rx_data;

  spi_adc_responder #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .rx_data(rx_data), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    logic [15:0] rx;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [11:0] m_hold = '0;
  logic [11:0] m_ramp = '0;
  logic [15:0] m_rx = '0;
  logic [15:0] cap_word = '0;
  logic        cap_extra = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_sample_ready", sample_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
  endtask

  // Scoreboard monitor: each completion or error pulse consumes one expected frame outcome.
  always @(negedge clk) begin
    if (rst_n && (frame_done || frame_err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: done=%0b err=%0b with empty queue", frame_done, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {frame_done, frame_err}, mon_e.done ? 2'b10 : 2'b01);
        check("rx_data", rx_data, mon_e.rx);
        if (mon_e.done) begin
          check("miso_word", cap_word, mon_e.word);
          check("miso_tail_zero", cap_extra, 0);
        end
      end
    end
  end

  task automatic load_sample(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    check("ready_idle", sample_ready, 1);
    @(negedge clk);
    sample_valid = 1'b0;
    if (!RAMP) m_hold = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    cs_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    m_hold = '0;
    m_rx   = '0;
    m_ramp = '0;
    repeat (10) @(negedge clk);
  endtask

  // mbits holds the MOSI stream right-aligned, bit nbits-1 sent first.
  task automatic frame(input int nbits, input logic [31:0] mbits, input int rst_at, input bit poke);
    exp_t        e;
    logic [11:0] tx;
    bit          oe_ok;
    tx = RAMP ? m_ramp : m_hold;
    if (rst_at == 0) begin
      e.done = (nbits >= FB);
      e.word = {4'b0000, tx};
      if (e.done) begin
        e.rx   = mbits[15:0];
        m_rx   = e.rx;
        m_ramp = m_ramp + 12'd1;
      end else begin
        e.rx = m_rx;
      end
      exp_q.push_back(e);
    end
    cap_word  = '0;
    cap_extra = 1'b0;
    oe_ok     = 1'b1;
    cs_n = 1'b0;
    mosi = mbits[nbits-1];
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) cap_word[15-i] = miso;
      else cap_extra = cap_extra | miso;
      oe_ok = oe_ok & miso_oe;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      if (poke && i == 5) begin
        sample_in    = 12'h111;
        sample_valid = 1'b1;
        check("ready_busy", sample_ready, 0);
        @(negedge clk);
        sample_valid = 1'b0;
      end
      if (rst_at == i + 1) begin
        do_reset();
        return;
      end
      sck = 1'b0;
      if (i + 1 < nbits) mosi = mbits[nbits-2-i];
      repeat (HALF) @(negedge clk);
    end
    check("oe_during_frame", oe_ok, 1);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (14) @(negedge clk);
    check("idle_miso", miso, 0);
    check("idle_miso_oe", miso_oe, 0);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    load_sample(12'hA5C);
    frame(16, 32'h0000_1234, 0, 1'b0);
    frame(9, $urandom, 0, 1'b0);
    frame(20, 32'h000F_FFF0, 0, 1'b0);
    frame(16, $urandom, 0, 1'b1);
    frame(16, $urandom, 0, 1'b0);

    load_sample(12'($urandom));
    frame(16, $urandom, 6, 1'b0);
    frame(16, $urandom, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) load_sample(12'($urandom));
      if ($urandom_range(0, 3) == 0) nb = $urandom_range(3, 15);
      else nb = $urandom_range(16, 19);
      frame(nb, $urandom, 0, 1'b0);
    end

`ifdef SPI_RESP_RAMP_EN
    force dut.ramp = 12'hFFF;
    @(negedge clk);
    release dut.ramp;
    m_ramp = 12'hFFF;
    frame(16, $urandom, 0, 1'b0);
    frame(16, $urandom, 0, 1'b0);
`endif

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

SPI responder that emulates a 12-bit serial ADC on the far end of the design's SPI link, so the SPI master and the LED and 7-segment display path can run on silicon or in simulation without an external converter. It samples the master's CS/SCK/MOSI with the system clock. Each frame returns one 16-bit word on MISO: 4 leading zeros followed by a 12-bit sample, MSB first. It also captures the 16 MOSI bits the master sends in the same frame.

## Interface
Parameters:
- `FRAME_BITS`, 16: SCK cycles per frame; the sample occupies the last 12 bits.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `cs_n` and `mosi`; legal values are 2 or 3.

Ports:
- `clk`  in  1: system clock. This is the only clock; `sck` is treated as data.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sck`  in  1: SPI clock from the master. Asynchronous to `clk`.
- `cs_n`  in  1: chip select from the master, active low. Asynchronous to `clk`.
- `mosi`  in  1: master-out data. Asynchronous to `clk`.
- `miso`  out  1: responder data output. It is registered.
- `miso_oe`  out  1: high while a frame is active, so the pad can drive `miso`.
- `sample_in`  in  12: next sample value.
- `sample_valid`  in  1: `sample_in` is valid in this cycle.
- `sample_ready`  out  1: high when the responder can accept a new sample.
- `rx_data`  out  16: last complete MOSI word, MSB first.
- `frame_done`  out  1: one-cycle pulse when a full frame completes.
- `frame_err`  out  1: one-cycle pulse when `cs_n` rises before `FRAME_BITS` rising edges.

## Operation
- The synchronized `sck` and `cs_n` feed edge detectors. These produce one-cycle pulses `sck_rise`, `sck_fall`, `cs_fall` and `cs_rise`.
- Sample buffer:
  - A one-entry holding register `hold`. It resets to 0x000.
  - A sample is accepted when `sample_valid && sample_ready`.
  - `sample_ready` = 1 whenever the FSM is in IDLE.
  - The latest accepted sample is the one used. There is no queue.
- FSM states:
  - IDLE to LOAD on `cs_fall`.
  - LOAD to SHIFT after 1 cycle. In LOAD: `shreg <= {4'b0, hold}`, `bitcnt <= 0`.
  - SHIFT to DONE when `bitcnt == FRAME_BITS` and `cs_rise`.
  - SHIFT to IDLE on `cs_rise` with `bitcnt < FRAME_BITS`. This pulses `frame_err`; `rx_data` is unchanged.
  - DONE to IDLE after 1 cycle. DONE pulses `frame_done` and copies `rxreg` to `rx_data`.
- Data direction: `miso` always shows `shreg[15]`.
- In SHIFT:
  - `sck_rise`: `rxreg <= {rxreg[14:0], mosi_sync}`, `bitcnt++`. `bitcnt` saturates at `FRAME_BITS`.
  - `sck_fall`: `shreg <= {shreg[14:0], 1'b0}`. This implements SPI mode 0 on the responder side: the master samples on the rising edge.
- Extra SCK edges beyond `FRAME_BITS`:
  - `miso` shifts out 0.
  - `rxreg` keeps shifting, so `rx_data` holds the last 16 bits received.
  - The frame still completes normally on `cs_rise`.
- Outside SHIFT and LOAD, `miso` = 0 and `miso_oe` = 0.
- Reset values: `miso` = 0, `miso_oe` = 0, `sample_ready` = 1, `rx_data` = 0x0000, `frame_done` = 0, `frame_err` = 0, FSM = IDLE.
- Reset asserted mid-frame: all state clears at once. The frame is lost and there is no `frame_err` pulse.

## Timing
- `sck` high and low phases must each be at least `SYNC_STAGES`+2 `clk` cycles. The `cs_n` setup time before the first SCK rising edge must be at least `SYNC_STAGES`+3 cycles. Faster SCK is unsupported and is not detected.
- Latency from a pin edge to its internal pulse is `SYNC_STAGES`+1 cycles.
- `miso` updates 1 cycle after `sck_fall`.
- `frame_done` asserts 2 cycles after `cs_rise`, for 1 cycle.
- `frame_err` asserts 1 cycle after `cs_rise`, for 1 cycle.
- A new `cs_fall` is honoured on the cycle after the FSM returns to IDLE.
- If `cs_fall` and a `sample_valid` handshake occur in the same cycle, the new sample is used in the frame.

## Configuration
- `SPI_RESP_RAMP_EN`:
  - Defined: `hold` is ignored for transmission. The transmitted sample is an internal 12-bit ramp. It resets to 0x000 and increments by 1 on each `frame_done`, wrapping from 0xFFF to 0x000. It is not advanced by `frame_err`. `sample_in` and `sample_valid` are ignored, and `sample_ready` still follows IDLE.
  - Undefined: frames transmit `hold` as described in Operation.

## Test plan
- Reset, then `sample_in` = 0xA5C with `sample_valid` pulsed in IDLE, then one 16-clock frame with MOSI = 0x1234 → MISO bits on the SCK rising edges read 0x0A5C; `rx_data` = 0x1234; one `frame_done`; `miso_oe` high only while CS is low.
- `cs_n` raised after 9 SCK cycles → one `frame_err` pulse, no `frame_done`, `rx_data` unchanged, `miso` = 0.
- Frame with 20 SCK cycles and MOSI = 0xFFFF then 0x0 → the last 4 MISO bits are 0; `rx_data` = 0xFFF0; `frame_done` = 1.
- `sample_valid` pulsed mid-frame with 0x111 → `sample_ready` = 0 and the value is ignored. The current frame is unchanged, and the next frame sends the previous `hold`.
- `rst_n` pulsed low at SCK cycle 6 → all outputs at reset values within 1 cycle; the next full frame completes correctly.
- With `SPI_RESP_RAMP_EN`: 3 frames send 0x000, 0x001, 0x002. After forcing the ramp to 0xFFF, the next two frames send 0xFFF then 0x000.
